// File: rtl/scramble_decoder.sv
// scramble_decoder: forwards dispatch commands and XOR-descrambles page/spare write data bound for RAM.
// Command out one cycle after accept; data has zero latency with combinational ready; define SCRAMBLE_DECODER_LENCHECK_EN for beat-count termination.
module scramble_decoder #(
  parameter int         AddressWidth       = 32,
  parameter int         DataWidth          = 32,
  parameter int         InnerIFLengthWidth = 16,
  parameter logic [4:0] ThisID             = 5'd4,
  parameter logic [5:0] OpPageWrite        = 6'b000001,
  parameter logic [5:0] OpSpareWrite       = 6'b000010
) (
  input  logic                          iClock,
  input  logic                          iReset_n,
  input  logic [5:0]                    iSrcOpcode,
  input  logic [4:0]                    iSrcTargetID,
  input  logic [4:0]                    iSrcSourceID,
  input  logic [AddressWidth-1:0]       iSrcAddress,
  input  logic [InnerIFLengthWidth-1:0] iSrcLength,
  input  logic                          iSrcCmdValid,
  output logic                          oSrcCmdReady,
  output logic [5:0]                    oDstOpcode,
  output logic [4:0]                    oDstTargetID,
  output logic [4:0]                    oDstSourceID,
  output logic [AddressWidth-1:0]       oDstAddress,
  output logic [InnerIFLengthWidth-1:0] oDstLength,
  output logic                          oDstCmdValid,
  input  logic                          iDstCmdReady,
  input  logic [DataWidth-1:0]          iSrcWriteData,
  input  logic                          iSrcWriteValid,
  input  logic                          iSrcWriteLast,
  output logic                          oSrcWriteReady,
  output logic [DataWidth-1:0]          oDstWriteData,
  output logic                          oDstWriteValid,
  output logic                          oDstWriteLast,
  input  logic                          iDstWriteReady
);

  localparam int LANES = DataWidth / 8;
  localparam int IW    = $clog2(LANES);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_BYP_CMD = 3'd1,
    S_BYP_TRF = 3'd2,
    S_DEC_CMD = 3'd3,
    S_DEC_TRF = 3'd4
  } state_t;

  state_t                        r_state;
  state_t                        w_next_state;
  logic [5:0]                    r_opcode;
  logic [4:0]                    r_target_id;
  logic [4:0]                    r_source_id;
  logic [AddressWidth-1:0]       r_address;
  logic [InnerIFLengthWidth-1:0] r_length;
  logic                          r_enable;
  logic [DataWidth-1:0]          r_row_address;
  logic [7:0]                    r_lfsr [LANES];
  logic [7:0]                    w_seed [LANES];
  logic [DataWidth-1:0]          w_key;
  logic                          w_is_ctrl;
  logic                          w_is_dec;
  logic                          w_in_trf;
  logic                          w_beat;
  logic                          w_last;

  assign w_is_ctrl = (iSrcTargetID == ThisID);
  assign w_is_dec  = r_enable && (iSrcTargetID == 5'd0) &&
                     ((iSrcOpcode == OpPageWrite) || (iSrcOpcode == OpSpareWrite));
  assign w_in_trf  = (r_state == S_BYP_TRF) || (r_state == S_DEC_TRF);
  assign w_beat    = w_in_trf && iSrcWriteValid && iDstWriteReady;

`ifdef SCRAMBLE_DECODER_LENCHECK_EN
  logic [InnerIFLengthWidth-1:0] r_beat_cnt;

  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      r_beat_cnt <= '0;
    end else if ((r_state == S_BYP_CMD) || (r_state == S_DEC_CMD)) begin
      r_beat_cnt <= r_length;
    end else if (w_beat) begin
      r_beat_cnt <= r_beat_cnt - 1'b1;
    end
  end

  assign w_last = iSrcWriteLast || (w_in_trf && (r_beat_cnt == InnerIFLengthWidth'(1)));
`else
  assign w_last = iSrcWriteLast;
`endif

  assign oDstWriteLast = w_last;
  assign oDstOpcode    = r_opcode;
  assign oDstTargetID  = r_target_id;
  assign oDstSourceID  = r_source_id;
  assign oDstAddress   = r_address;
  assign oDstLength    = r_length;

  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state   = r_state;
    oSrcCmdReady   = 1'b0;
    oDstCmdValid   = 1'b0;
    oDstWriteValid = 1'b0;
    oSrcWriteReady = 1'b0;
    oDstWriteData  = iSrcWriteData;
    case (r_state)
      S_IDLE: begin
        oSrcCmdReady = 1'b1;
        if (iSrcCmdValid && !w_is_ctrl) begin
          w_next_state = w_is_dec ? S_DEC_CMD : S_BYP_CMD;
        end
      end
      S_BYP_CMD, S_DEC_CMD: begin
        oDstCmdValid = 1'b1;
        if (iDstCmdReady) begin
          if (r_length == '0) begin
            w_next_state = S_IDLE;
          end else begin
            w_next_state = (r_state == S_DEC_CMD) ? S_DEC_TRF : S_BYP_TRF;
          end
        end
      end
      S_BYP_TRF, S_DEC_TRF: begin
        oDstWriteValid = iSrcWriteValid;
        oSrcWriteReady = iDstWriteReady;
        if (r_state == S_DEC_TRF) begin
          oDstWriteData = iSrcWriteData ^ w_key;
        end
        if (w_beat && w_last) begin
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Fields are latched for every accepted command; control ones are simply never forwarded.
  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      r_opcode      <= '0;
      r_target_id   <= '0;
      r_source_id   <= '0;
      r_address     <= '0;
      r_length      <= '0;
      r_enable      <= 1'b1;
      r_row_address <= '0;
    end else if ((r_state == S_IDLE) && iSrcCmdValid) begin
      r_opcode    <= iSrcOpcode;
      r_target_id <= iSrcTargetID;
      r_source_id <= iSrcSourceID;
      r_address   <= iSrcAddress;
      r_length    <= iSrcLength;
      if (w_is_ctrl) begin
        if (iSrcOpcode == 6'b000001) begin
          r_enable <= 1'b0;
        end else if (iSrcOpcode == 6'b000011) begin
          r_enable <= 1'b1;
        end else begin
          r_row_address <= iSrcAddress[DataWidth-1:0];
        end
      end
    end
  end

  always_comb begin
    logic [7:0] v_seed;
    w_key = '0;
    for (int i = 0; i < LANES; i++) begin
      v_seed    = (r_row_address[7:0] << IW) | 8'(i);
      w_seed[i] = (v_seed == 8'h00) ? 8'h01 : v_seed;
      w_key[8*i +: 8] = r_lfsr[i];
    end
  end

  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      for (int i = 0; i < LANES; i++) r_lfsr[i] <= '0;
    end else if (r_state == S_DEC_CMD) begin
      for (int i = 0; i < LANES; i++) r_lfsr[i] <= w_seed[i];
    end else if (w_beat && (r_state == S_DEC_TRF)) begin
      for (int i = 0; i < LANES; i++) begin
        r_lfsr[i] <= {r_lfsr[i][6:0], r_lfsr[i][7] ^ r_lfsr[i][5] ^ r_lfsr[i][4] ^ r_lfsr[i][3]};
      end
    end
  end

endmodule

// File: tb/tb_scramble_decoder.sv
// Randomized bench for scramble_decoder with a keystream model computed per (row, lane, beat index).
module tb_scramble_decoder;
  localparam int DW    = 32;
  localparam int LANES = DW / 8;
  localparam int IW    = 2;

  logic          iClock = 1'b0;
  logic          iReset_n;
  logic [5:0]    iSrcOpcode;
  logic [4:0]    iSrcTargetID, iSrcSourceID;
  logic [31:0]   iSrcAddress;
  logic [15:0]   iSrcLength;
  logic          iSrcCmdValid, oSrcCmdReady;
  logic [5:0]    oDstOpcode;
  logic [4:0]    oDstTargetID, oDstSourceID;
  logic [31:0]   oDstAddress;
  logic [15:0]   oDstLength;
  logic          oDstCmdValid, iDstCmdReady;
  logic [DW-1:0] iSrcWriteData, oDstWriteData;
  logic          iSrcWriteValid, iSrcWriteLast, oSrcWriteReady;
  logic          oDstWriteValid, oDstWriteLast, iDstWriteReady;

  int          total = 0;
  int          bad   = 0;
  logic        tb_enable;
  logic [31:0] tb_row;

  scramble_decoder dut (
    .iClock(iClock), .iReset_n(iReset_n),
    .iSrcOpcode(iSrcOpcode), .iSrcTargetID(iSrcTargetID), .iSrcSourceID(iSrcSourceID),
    .iSrcAddress(iSrcAddress), .iSrcLength(iSrcLength),
    .iSrcCmdValid(iSrcCmdValid), .oSrcCmdReady(oSrcCmdReady),
    .oDstOpcode(oDstOpcode), .oDstTargetID(oDstTargetID), .oDstSourceID(oDstSourceID),
    .oDstAddress(oDstAddress), .oDstLength(oDstLength),
    .oDstCmdValid(oDstCmdValid), .iDstCmdReady(iDstCmdReady),
    .iSrcWriteData(iSrcWriteData), .iSrcWriteValid(iSrcWriteValid),
    .iSrcWriteLast(iSrcWriteLast), .oSrcWriteReady(oSrcWriteReady),
    .oDstWriteData(oDstWriteData), .oDstWriteValid(oDstWriteValid),
    .oDstWriteLast(oDstWriteLast), .iDstWriteReady(iDstWriteReady)
  );

  always #5 iClock = ~iClock;

  // Keystream word for beat k: each lane seeded from the row and lane number, then stepped k times.
  function automatic logic [DW-1:0] ref_key(input logic [31:0] row, input int k);
    logic [DW-1:0] key;
    logic [7:0]    s;
    key = '0;
    for (int l = 0; l < LANES; l++) begin
      s = 8'((int'(row[7:0]) % (1 << (8 - IW))) * (1 << IW) + l);
      if (s == 8'h00) s = 8'h01;
      for (int j = 0; j < k; j++) s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
      key[8*l +: 8] = s;
    end
    return key;
  endfunction

  task automatic do_cmd(input logic [5:0] op, input logic [4:0] tgt, input logic [31:0] addr,
                        input logic [15:0] len);
    iSrcOpcode   = op;
    iSrcTargetID = tgt;
    iSrcSourceID = 5'($urandom);
    iSrcAddress  = addr;
    iSrcLength   = len;
    iSrcCmdValid = 1'b1;
    @(posedge iClock); #1;
    iSrcCmdValid = 1'b0;
    if (tgt == 5'd4) begin
      if (op == 6'b000001) tb_enable = 1'b0;
      else if (op == 6'b000011) tb_enable = 1'b1;
      else tb_row = addr;
    end
  endtask

  task automatic test_reset;
    iReset_n = 1'b0;
    iSrcWriteLast = 1'b1;
    @(negedge iClock);
    total++;
    if ({oSrcCmdReady, oDstCmdValid, oDstWriteValid, oSrcWriteReady} !== 4'b1000) begin
      bad++;
      $display("FAIL reset_handshake got=%b exp=1000",
               {oSrcCmdReady, oDstCmdValid, oDstWriteValid, oSrcWriteReady});
    end
    total++;
    if ({oDstOpcode, oDstTargetID, oDstSourceID, oDstAddress, oDstLength} !== '0) begin
      bad++;
      $display("FAIL reset_cmd_fields got=%h exp=0",
               {oDstOpcode, oDstTargetID, oDstSourceID, oDstAddress, oDstLength});
    end
    total++;
    if (oDstWriteLast !== 1'b1) begin
      bad++;
      $display("FAIL reset_last_follow got=%b exp=1", oDstWriteLast);
    end
    @(posedge iClock); #1;
    iReset_n = 1'b1;
    iSrcWriteLast = 1'b0;
    tb_enable = 1'b1;
    tb_row = '0;
  endtask

  task automatic test_scramble;
    logic [31:0] addr;
    addr = $urandom;
    iDstCmdReady = 1'b1;
    do_cmd(6'b000010, 5'd4, 32'h5, 16'd0);
    do_cmd(6'b000001, 5'd0, addr, 16'd2);
    @(negedge iClock);
    total++;
    if ({oDstCmdValid, oDstOpcode, oDstTargetID, oDstAddress, oDstLength} !==
        {1'b1, 6'b000001, 5'd0, addr, 16'd2}) begin
      bad++;
      $display("FAIL scr_cmd_out got=%h exp=%h",
               {oDstCmdValid, oDstOpcode, oDstTargetID, oDstAddress, oDstLength},
               {1'b1, 6'b000001, 5'd0, addr, 16'd2});
    end
    total++;
    if (oSrcWriteReady !== 1'b0) begin
      bad++;
      $display("FAIL scr_no_data_rdy_in_cmd got=%b exp=0", oSrcWriteReady);
    end
    @(posedge iClock); #1;
    iSrcWriteData = 32'hFFFF_FFFF; iSrcWriteValid = 1'b1; iSrcWriteLast = 1'b0; iDstWriteReady = 1'b1;
    @(negedge iClock);
    total++;
    if (oDstWriteData !== 32'hE8E9_EAEB) begin
      bad++;
      $display("FAIL scr_beat0 got=%h exp=e8e9eaeb", oDstWriteData);
    end
    total++;
    if ({oDstWriteValid, oSrcWriteReady, oDstWriteLast} !== 3'b110) begin
      bad++;
      $display("FAIL scr_beat0_ctl got=%b exp=110", {oDstWriteValid, oSrcWriteReady, oDstWriteLast});
    end
    @(posedge iClock); #1;
    iSrcWriteData = 32'h0; iSrcWriteLast = 1'b1;
    @(negedge iClock);
    total++;
    if (oDstWriteData[7:0] !== 8'h29) begin
      bad++;
      $display("FAIL scr_beat1_lane0 got=%h exp=29", oDstWriteData[7:0]);
    end
    total++;
    if (oDstWriteData !== ref_key(tb_row, 1)) begin
      bad++;
      $display("FAIL scr_beat1_word got=%h exp=%h", oDstWriteData, ref_key(tb_row, 1));
    end
    @(posedge iClock); #1;
    iSrcWriteValid = 1'b0; iSrcWriteLast = 1'b0;
    @(negedge iClock);
    total++;
    if ({oSrcCmdReady, oDstWriteValid, oSrcWriteReady} !== 3'b100) begin
      bad++;
      $display("FAIL scr_back_idle got=%b exp=100", {oSrcCmdReady, oDstWriteValid, oSrcWriteReady});
    end
  endtask

  task automatic test_disable;
    iDstCmdReady = 1'b1;
    do_cmd(6'b000001, 5'd4, 32'h0, 16'd0);
    do_cmd(6'b000001, 5'd0, $urandom, 16'd1);
    @(negedge iClock);
    total++;
    if (oDstCmdValid !== 1'b1) begin
      bad++;
      $display("FAIL dis_cmd_vld got=%b exp=1", oDstCmdValid);
    end
    @(posedge iClock); #1;
    iSrcWriteData = 32'h1234_5678; iSrcWriteValid = 1'b1; iSrcWriteLast = 1'b1; iDstWriteReady = 1'b1;
    @(negedge iClock);
    total++;
    if (oDstWriteData !== 32'h1234_5678) begin
      bad++;
      $display("FAIL dis_passthrough got=%h exp=12345678", oDstWriteData);
    end
    @(posedge iClock); #1;
    iSrcWriteValid = 1'b0; iSrcWriteLast = 1'b0;
    do_cmd(6'b000011, 5'd4, 32'h0, 16'd0);
  endtask

  task automatic test_zero_len;
    iDstCmdReady = 1'b0;
    iDstWriteReady = 1'b1;
    do_cmd(6'b000101, 5'd0, $urandom, 16'd0);
    @(negedge iClock);
    total++;
    if ({oDstCmdValid, oSrcCmdReady} !== 2'b10) begin
      bad++;
      $display("FAIL zl_cmd_vld got=%b exp=10", {oDstCmdValid, oSrcCmdReady});
    end
    @(posedge iClock); #1;
    @(negedge iClock);
    total++;
    if ({oDstCmdValid, oSrcWriteReady} !== 2'b10) begin
      bad++;
      $display("FAIL zl_cmd_hold got=%b exp=10", {oDstCmdValid, oSrcWriteReady});
    end
    iDstCmdReady = 1'b1;
    @(posedge iClock); #1;
    @(negedge iClock);
    total++;
    if ({oDstCmdValid, oSrcCmdReady, oSrcWriteReady} !== 3'b010) begin
      bad++;
      $display("FAIL zl_back_idle got=%b exp=010", {oDstCmdValid, oSrcCmdReady, oSrcWriteReady});
    end
  endtask

  task automatic test_stall;
    int pat [4] = '{1, 0, 1, 1};
    int k;
    logic [31:0] d;
    k = 0;
    iDstCmdReady = 1'b1;
    do_cmd(6'b000111, 5'd4, $urandom, 16'd0);
    do_cmd(6'b000010, 5'd0, $urandom, 16'd3);
    @(posedge iClock); #1;
    for (int c = 0; c < 4; c++) begin
      d = $urandom;
      iSrcWriteData = d; iSrcWriteValid = 1'b1; iSrcWriteLast = (k == 2);
      iDstWriteReady = (pat[c] != 0);
      @(negedge iClock);
      total++;
      if (oDstWriteData !== (d ^ ref_key(tb_row, k))) begin
        bad++;
        $display("FAIL stall_data c=%0d got=%h exp=%h", c, oDstWriteData, d ^ ref_key(tb_row, k));
      end
      total++;
      if (oSrcWriteReady !== iDstWriteReady) begin
        bad++;
        $display("FAIL stall_rdy c=%0d got=%b exp=%b", c, oSrcWriteReady, iDstWriteReady);
      end
      @(posedge iClock); #1;
      if (pat[c] != 0) k++;
    end
    iSrcWriteValid = 1'b0; iSrcWriteLast = 1'b0;
    @(negedge iClock);
    total++;
    if (oSrcCmdReady !== 1'b1) begin
      bad++;
      $display("FAIL stall_back_idle got=%b exp=1", oSrcCmdReady);
    end
  endtask

  task automatic test_seed_zero;
    iDstCmdReady = 1'b1;
    do_cmd(6'b000000, 5'd4, 32'h0, 16'd0);
    do_cmd(6'b000001, 5'd0, $urandom, 16'd2);
    @(posedge iClock); #1;
    for (int k = 0; k < 2; k++) begin
      iSrcWriteData = '0; iSrcWriteValid = 1'b1; iSrcWriteLast = (k == 1); iDstWriteReady = 1'b1;
      @(negedge iClock);
      total++;
      if (oDstWriteData[7:0] !== ((k == 0) ? 8'h01 : 8'h02)) begin
        bad++;
        $display("FAIL seed0_lane0 k=%0d got=%h exp=%h", k, oDstWriteData[7:0], (k == 0) ? 8'h01 : 8'h02);
      end
      total++;
      if (oDstWriteData !== ref_key(tb_row, k)) begin
        bad++;
        $display("FAIL seed0_word k=%0d got=%h exp=%h", k, oDstWriteData, ref_key(tb_row, k));
      end
      @(posedge iClock); #1;
    end
    iSrcWriteValid = 1'b0; iSrcWriteLast = 1'b0;
  endtask

  task automatic test_reset_mid;
    iDstCmdReady = 1'b1;
    do_cmd(6'b000100, 5'd4, $urandom, 16'd0);
    do_cmd(6'b000001, 5'd0, $urandom, 16'd4);
    @(posedge iClock); #1;
    iSrcWriteData = $urandom; iSrcWriteValid = 1'b1; iDstWriteReady = 1'b1;
    @(negedge iClock);
    total++;
    if (oDstWriteValid !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_in_trf got=%b exp=1", oDstWriteValid);
    end
    #2 iReset_n = 1'b0;
    #1;
    total++;
    if ({oSrcCmdReady, oDstCmdValid, oDstWriteValid, oSrcWriteReady} !== 4'b1000) begin
      bad++;
      $display("FAIL rstmid_idle got=%b exp=1000",
               {oSrcCmdReady, oDstCmdValid, oDstWriteValid, oSrcWriteReady});
    end
    @(posedge iClock); #1;
    iReset_n = 1'b1; iSrcWriteValid = 1'b0;
    tb_enable = 1'b1; tb_row = '0;
  endtask

  task automatic test_random;
    for (int n = 0; n < 40; n++) begin
      int          kind, wait_cyc, len, k;
      logic [5:0]  op;
      logic [4:0]  tgt;
      logic [31:0] addr, d;
      logic        dec, v, r;
      kind = $urandom_range(0, 3);
      addr = $urandom;
      if (kind == 0) begin
        op = 6'($urandom_range(0, 3));
        do_cmd(op, 5'd4, addr, 16'($urandom_range(0, 4)));
        @(negedge iClock);
        total++;
        if ({oDstCmdValid, oSrcCmdReady} !== 2'b01) begin
          bad++;
          $display("FAIL rnd_ctrl_consumed n=%0d got=%b exp=01", n, {oDstCmdValid, oSrcCmdReady});
        end
      end else begin
        tgt = (kind == 1) ? 5'd0 : 5'($urandom_range(0, 31));
        if (tgt == 5'd4) tgt = 5'd0;
        op  = (kind == 1) ? 6'($urandom_range(1, 2)) : 6'($urandom_range(0, 63));
        len = $urandom_range(0, 4);
        dec = tb_enable && (tgt == 5'd0) && ((op == 6'd1) || (op == 6'd2));
        do_cmd(op, tgt, addr, 16'(len));
        wait_cyc = $urandom_range(0, 2);
        for (int w = 0; w <= wait_cyc; w++) begin
          iDstCmdReady = (w == wait_cyc);
          @(negedge iClock);
          total++;
          if ({oDstCmdValid, oDstOpcode, oDstTargetID, oDstAddress, oDstLength} !==
              {1'b1, op, tgt, addr, 16'(len)}) begin
            bad++;
            $display("FAIL rnd_cmd n=%0d got=%h exp=%h", n,
                     {oDstCmdValid, oDstOpcode, oDstTargetID, oDstAddress, oDstLength},
                     {1'b1, op, tgt, addr, 16'(len)});
          end
          @(posedge iClock); #1;
        end
        k = 0;
        for (int c = 0; c < 64 && k < len; c++) begin
          d = $urandom;
          v = (c >= 16) || ($urandom_range(0, 3) != 0);
          r = (c >= 16) || ($urandom_range(0, 3) != 0);
          iSrcWriteData = d; iSrcWriteValid = v; iDstWriteReady = r; iSrcWriteLast = (k == len - 1);
          @(negedge iClock);
          total++;
          if (oDstWriteData !== (dec ? (d ^ ref_key(tb_row, k)) : d)) begin
            bad++;
            $display("FAIL rnd_data n=%0d k=%0d got=%h exp=%h", n, k, oDstWriteData,
                     dec ? (d ^ ref_key(tb_row, k)) : d);
          end
          total++;
          if ({oDstWriteValid, oSrcWriteReady, oDstWriteLast} !== {v, r, (k == len - 1)}) begin
            bad++;
            $display("FAIL rnd_ctl n=%0d k=%0d got=%b exp=%b", n, k,
                     {oDstWriteValid, oSrcWriteReady, oDstWriteLast}, {v, r, (k == len - 1)});
          end
          @(posedge iClock); #1;
          if (v && r) k++;
        end
        iSrcWriteValid = 1'b0; iSrcWriteLast = 1'b0;
        @(negedge iClock);
        total++;
        if ({oSrcCmdReady, oDstCmdValid, oDstWriteValid} !== 3'b100) begin
          bad++;
          $display("FAIL rnd_back_idle n=%0d got=%b exp=100", n,
                   {oSrcCmdReady, oDstCmdValid, oDstWriteValid});
        end
      end
      @(posedge iClock); #1;
    end
  endtask

  initial begin
    iReset_n = 1'b0;
    iSrcOpcode = '0; iSrcTargetID = '0; iSrcSourceID = '0; iSrcAddress = '0; iSrcLength = '0;
    iSrcCmdValid = 1'b0; iDstCmdReady = 1'b1;
    iSrcWriteData = '0; iSrcWriteValid = 1'b0; iSrcWriteLast = 1'b0; iDstWriteReady = 1'b0;
    tb_enable = 1'b1; tb_row = '0;
    test_reset();
    test_scramble();
    test_disable();
    test_zero_len();
    test_stall();
    test_seed_zero();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
